draw_image: RTL and testbench
=============================

DRAW_IMAGE -- requirements
Module: draw_image

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameters SHALL be:
- IMG_W, default 128, image width in pixels (1..128).
- IMG_H, default 256, image height in pixels (1..256).
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, pixel clock.
- rst, in, 1, synchronous active-high reset.
- xpos, in, 12, requested image left column.
- ypos, in, 12, requested image top row.
- pos_valid, in, 1, one-cycle strobe that captures xpos/ypos.
- vcount_in, in, 11, vertical pixel counter.
- vsync_in, in, 1, vertical sync.
- vblnk_in, in, 1, vertical blank.
- hcount_in, in, 11, horizontal pixel counter.
- hsync_in, in, 1, horizontal sync.
- hblnk_in, in, 1, horizontal blank.
- rgb_in, in, 12, background pixel.
- rom_address, out, 15, image ROM address {row[7:0], col[6:0]}.
- rom_rgb, in, 12, image ROM data, valid 1 clk after rom_address.
- vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out, rgb_out, out, same widths, delayed or overlaid stream.

Function
REQ-004 The block SHALL have a fixed latency of 3 clk, input to output, for every VGA timing signal; the timing outputs SHALL equal the inputs delayed by exactly 3 cycles.
REQ-005 Stage 1 SHALL register rom_address, in_window and the timing signals.
REQ-006 Stage 2 SHALL wait for rom_rgb.
REQ-007 Stage 3 SHALL register rgb_out.
REQ-008 in_window SHALL be 1 only when all of the following hold, else 0:
- hblnk_in=0 and vblnk_in=0;
- act_x <= hcount_in <= act_x+IMG_W-1;
- act_y <= vcount_in <= act_y+IMG_H-1.
REQ-009 The window comparisons SHALL use 13-bit unsigned arithmetic, so an image that runs past 4095 is clipped and never wraps.
REQ-010 When in_window=1, rom_address SHALL be {(vcount_in-act_y)[7:0], (hcount_in-act_x)[6:0]}; otherwise rom_address SHALL be 0.
REQ-011 rgb_out SHALL be rom_rgb when the delayed in_window=1, else the 2-cycle-delayed rgb_in.
REQ-012 Position update FSM, states IDLE and PENDING:
- pos_valid=1 SHALL load pend_x/pend_y and enter PENDING.
- In PENDING, a vblnk_in rising edge (0 to 1) SHALL copy pend to act_x/act_y and return to IDLE.
REQ-013 If pos_valid arrives again while in PENDING, pend SHALL be overwritten and only the last pair SHALL be applied.
REQ-014 If pos_valid coincides with a vblnk_in rising edge, the previously pending pair SHALL be applied (if the FSM is in PENDING); the new pair SHALL be stored, and the FSM SHALL stay in or enter PENDING for the next frame.
REQ-015 act_x/act_y SHALL never change outside a vblnk_in rising edge, so there is no tearing within a frame.

Reset
REQ-016 On rst=1, the FSM SHALL go to IDLE and act_x, act_y, pend_x, pend_y SHALL be 0.
REQ-017 On rst=1, all pipeline registers and all outputs SHALL be 0.
REQ-018 While rst=1 and for 3 clk after release, outputs SHALL show only flushed zeros or pipeline contents; no stale image pixels SHALL appear.
REQ-019 A reset mid-frame SHALL discard any pending position.

Configuration
REQ-020 With DRAW_IMAGE_TRANSPARENCY_EN defined, a ROM pixel equal to TRANSPARENT_KEY (12'hF0F) SHALL output the delayed rgb_in instead.
REQ-021 Without DRAW_IMAGE_TRANSPARENCY_EN, every in-window ROM pixel SHALL be output, including 12'hF0F.

Structure
REQ-022 Package draw_image_pkg SHALL hold:
- IMG_W_MAX=128, IMG_H_MAX=256, ROM_AW=15;
- TRANSPARENT_KEY=12'hF0F;
- the FSM state enum.
REQ-023 Sub-module vga_delay SHALL implement the parameterised N-stage delay of the 6 timing signals (N=3) and of rgb_in (N=2).

Verification
REQ-024 After reset, with no pos_valid and a 640x480 stream:
- rgb_out(hcount=0, vcount=0) SHALL be rom[0];
- timing outputs SHALL be the inputs delayed by 3 cycles.
REQ-025 With pos_valid (xpos=100, ypos=50) in mid-frame:
- the current frame SHALL be unchanged;
- from the next frame, pixel (100,50) SHALL show rom[15'h0000] and pixel (227,305) SHALL show rom[{8'd255, 7'd127}];
- pixel (228,50) SHALL show the background.
REQ-026 With xpos=4090, the window SHALL be clipped: columns 4090..4095 only, with no image pixels at hcount 0..121.
REQ-027 Two pos_valid strobes (10,10) then (20,20) in one frame SHALL result in only (20,20) being applied at the next vblnk rising edge.
REQ-028 A pos_valid on the exact cycle of a vblnk rising edge SHALL be applied one frame later; assert rst mid-frame while PENDING and check act stays (0,0).
REQ-029 With DRAW_IMAGE_TRANSPARENCY_EN, ROM data 12'hF0F SHALL output rgb_in=12'h123; with the macro undefined, it SHALL output 12'hF0F.

Source files
------------

// File: rtl/draw_image_pkg.sv
// ============================================================================
// Module      : draw_image_pkg
// Description : Shared constants and the position-update state type for draw_image.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package draw_image_pkg;

  localparam int IMG_W_MAX = 128;
  localparam int IMG_H_MAX = 256;
  localparam int ROM_AW    = 15;

  localparam logic [11:0] TRANSPARENT_KEY = 12'hF0F;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  typedef enum logic [0:0] {
    POS_IDLE    = ST_IDLE,
    POS_PENDING = ST_PENDING
  } pos_state_e;

endpackage

`default_nettype wire

// File: rtl/vga_delay.sv
// ============================================================================
// Module      : vga_delay
// Description : N-stage register delay line, W bits wide, synchronously cleared.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module vga_delay #(
  parameter int N = 3,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  logic [N-1:0][W-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < N; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[N-1];

endmodule

`default_nettype wire

// File: rtl/draw_image.sv
// ============================================================================
// Module      : draw_image
// Description : Overlays an IMG_W x IMG_H ROM image on a VGA stream, 3-clk latency.
//               DRAW_IMAGE_TRANSPARENCY_EN: ROM pixels equal to TRANSPARENT_KEY
//               show the background instead.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module draw_image
  import draw_image_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic              pos_valid,
  input  logic [10:0]       vcount_in,
  input  logic              vsync_in,
  input  logic              vblnk_in,
  input  logic [10:0]       hcount_in,
  input  logic              hsync_in,
  input  logic              hblnk_in,
  input  logic [11:0]       rgb_in,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [11:0]       rom_rgb,
  output logic [10:0]       vcount_out,
  output logic              vsync_out,
  output logic              vblnk_out,
  output logic [10:0]       hcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic [11:0]       rgb_out
);

  pos_state_e  state_q, state_d;
  logic [11:0] act_x_q, act_x_d, act_y_q, act_y_d;
  logic [11:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic        vblnk_prev_q;
  logic        w_vblnk_rise;

  assign w_vblnk_rise = vblnk_in & ~vblnk_prev_q;

  // act only moves on a vblank rising edge, so a frame never tears.
  always_comb begin
    state_d  = state_q;
    act_x_d  = act_x_q;
    act_y_d  = act_y_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    if (w_vblnk_rise && state_q == POS_PENDING) begin
      act_x_d = pend_x_q;
      act_y_d = pend_y_q;
    end
    if (pos_valid) begin
      pend_x_d = xpos;
      pend_y_d = ypos;
      state_d  = POS_PENDING;
    end else if (w_vblnk_rise) begin
      state_d  = POS_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= POS_IDLE;
      act_x_q      <= '0;
      act_y_q      <= '0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      vblnk_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_x_q      <= act_x_d;
      act_y_q      <= act_y_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      vblnk_prev_q <= vblnk_in;
    end
  end

  // 13-bit window bounds: an image reaching past 4095 clips instead of wrapping.
  logic [12:0] w_h, w_v, w_x0, w_x1, w_y0, w_y1;
  logic        w_in_window;
  logic [6:0]  w_dx;
  logic [7:0]  w_dy;
  logic [ROM_AW-1:0] w_rom_addr;

  assign w_h  = {2'b00, hcount_in};
  assign w_v  = {2'b00, vcount_in};
  assign w_x0 = {1'b0, act_x_q};
  assign w_y0 = {1'b0, act_y_q};
  assign w_x1 = w_x0 + 13'(IMG_W - 1);
  assign w_y1 = w_y0 + 13'(IMG_H - 1);

  assign w_in_window = ~hblnk_in & ~vblnk_in &
                       (w_h >= w_x0) & (w_h <= w_x1) &
                       (w_v >= w_y0) & (w_v <= w_y1);

  assign w_dx       = w_h[6:0] - w_x0[6:0];
  assign w_dy       = w_v[7:0] - w_y0[7:0];
  assign w_rom_addr = w_in_window ? {w_dy, w_dx} : '0;

  logic [ROM_AW-1:0] rom_addr_q;
  logic              in_win1_q, in_win2_q;
  logic [11:0]       rgb_q;
  logic [11:0]       w_rgb_dly;
  logic              w_transparent;
  logic              w_use_rom;

`ifdef DRAW_IMAGE_TRANSPARENCY_EN
  assign w_transparent = (rom_rgb == TRANSPARENT_KEY);
`else
  assign w_transparent = 1'b0;
`endif

  assign w_use_rom = in_win2_q & ~w_transparent;

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= '0;
      in_win1_q  <= 1'b0;
      in_win2_q  <= 1'b0;
      rgb_q      <= '0;
    end else begin
      rom_addr_q <= w_rom_addr;
      in_win1_q  <= w_in_window;
      in_win2_q  <= in_win1_q;
      rgb_q      <= w_use_rom ? rom_rgb : w_rgb_dly;
    end
  end

  assign rom_address = rom_addr_q;
  assign rgb_out     = rgb_q;

  vga_delay #(.N(3), .W(26)) u_timing_dly (
    .clk    (clk),
    .rst    (rst),
    .data_i ({vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in}),
    .data_o ({vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out})
  );

  vga_delay #(.N(2), .W(12)) u_rgb_dly (
    .clk    (clk),
    .rst    (rst),
    .data_i (rgb_in),
    .data_o (w_rgb_dly)
  );

endmodule

`default_nettype wire

// File: tb/tb_draw_image.sv
// ============================================================================
// Module      : tb_draw_image
// Description : Directed-vector self-checking bench for draw_image.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_draw_image;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic        pos_valid;
  logic [10:0] vcount_in, hcount_in;
  logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
  logic [11:0] rgb_in;
  logic [14:0] rom_address;
  logic [11:0] rom_rgb;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic [11:0] rgb_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  draw_image #(.IMG_W(128), .IMG_H(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .xpos       (xpos),
    .ypos       (ypos),
    .pos_valid  (pos_valid),
    .vcount_in  (vcount_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .hcount_in  (hcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .rgb_in     (rgb_in),
    .rom_address(rom_address),
    .rom_rgb    (rom_rgb),
    .vcount_out (vcount_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .hcount_out (hcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .rgb_out    (rgb_out)
  );

  // Image ROM: one-cycle read latency, one texel planted with the key colour.
  localparam logic [14:0] KEY_ADDR = {8'd64, 7'd64};

  function automatic logic [11:0] rom_val(input logic [14:0] a);
    if (a == KEY_ADDR) return 12'hF0F;
    return a[11:0] ^ {a[14:12], 9'h000} ^ 12'hA5A;
  endfunction

  function automatic logic [11:0] bg(input logic [10:0] h, input logic [10:0] v);
    return 12'h123 ^ {h[5:0], v[5:0]};
  endfunction

  always_ff @(posedge clk) rom_rgb <= rom_val(rom_address);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pos_valid = 1'b0;
    hblnk_in  = 1'b1;
    vblnk_in  = 1'b0;
    hsync_in  = 1'b0;
    vsync_in  = 1'b0;
    hcount_in = '0;
    vcount_in = '0;
    rgb_in    = 12'hEEE;
  endtask

  // Drive one visible pixel, then blanking; check ROM address and final colour.
  task automatic pix(input int h, input int v, input bit inwin,
                     input int row, input int col, input string tag);
    logic [14:0] a;
    logic [11:0] e;
    a = inwin ? {8'(row), 7'(col)} : 15'd0;
    e = inwin ? rom_val(a) : bg(11'(h), 11'(v));
    idle_inputs();
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = 1'b0;
    rgb_in    = bg(11'(h), 11'(v));
    step();
    check({tag, "_addr"}, 32'(rom_address), 32'(a));
    idle_inputs();
    step();
    step();
    check(tag, 32'(rgb_out), 32'(e));
  endtask

  task automatic pos(input int x, input int y);
    idle_inputs();
    xpos      = 12'(x);
    ypos      = 12'(y);
    pos_valid = 1'b1;
    step();
    pos_valid = 1'b0;
    step();
  endtask

  // Frame boundary; optionally strobe a new position on the rising-edge cycle.
  task automatic frame(input bit with_pos, input int x, input int y);
    idle_inputs();
    step();
    vblnk_in  = 1'b1;
    pos_valid = with_pos;
    xpos      = 12'(x);
    ypos      = 12'(y);
    step();
    pos_valid = 1'b0;
    step();
    vblnk_in  = 1'b0;
    step();
  endtask

  logic [25:0] hist [0:11];

  initial begin
    xpos = '0;
    ypos = '0;
    idle_inputs();
    rst = 1'b1;
    hblnk_in  = 1'b0;
    hcount_in = 11'd7;
    vcount_in = 11'd9;
    vsync_in  = 1'b1;
    rgb_in    = 12'h5A5;
    repeat (4) step();
    check("rst_rgb",    32'(rgb_out), 32'h0);
    check("rst_addr",   32'(rom_address), 32'h0);
    check("rst_timing", 32'({vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out}), 32'h0);
    rst = 1'b0;

    // Timing outputs are the inputs three clocks later.
    for (int i = 0; i < 12; i++) begin
      hist[i] = 26'($urandom);
      {vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in} = hist[i];
      rgb_in = 12'($urandom);
      step();
      if (i >= 2)
        check("timing_dly", 32'({vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out}),
              32'(hist[i-2]));
    end
    idle_inputs();
    step();

    // Default position (0,0).
    pix(0,   0,   1'b1, 0,   0,   "p0_origin");
    pix(5,   3,   1'b1, 3,   5,   "p0_5_3");
    pix(127, 255, 1'b1, 255, 127, "p0_corner");
    pix(128, 0,   1'b0, 0,   0,   "p0_right");
    pix(0,   256, 1'b0, 0,   0,   "p0_below");

    // New position mid-frame waits for the next vblank edge.
    pos(100, 50);
    pix(100, 50,  1'b1, 50,  100, "p1_same_frame");
    frame(1'b0, 0, 0);
    pix(100, 50,  1'b1, 0,   0,   "p1_origin");
    pix(227, 305, 1'b1, 255, 127, "p1_corner");
    pix(228, 50,  1'b0, 0,   0,   "p1_right");
    pix(99,  50,  1'b0, 0,   0,   "p1_left");

    // Far-right position clips; nothing visible at low columns.
    pos(4090, 0);
    frame(1'b0, 0, 0);
    pix(0,    0, 1'b0, 0, 0, "clip_h0");
    pix(121,  0, 1'b0, 0, 0, "clip_h121");
    pix(2047, 0, 1'b0, 0, 0, "clip_h2047");

    // Two strobes in one frame: only the last is applied.
    pos(10, 10);
    pix(3, 3, 1'b0, 0, 0, "dbl_mid");
    pos(20, 20);
    frame(1'b0, 0, 0);
    pix(20,  20, 1'b1, 0, 0,   "dbl_origin");
    pix(147, 20, 1'b1, 0, 127, "dbl_right");
    pix(10,  10, 1'b0, 0, 0,   "dbl_first");

    // Strobe on the vblank edge while idle: applied one frame later.
    frame(1'b1, 30, 40);
    pix(20, 20, 1'b1, 0, 0, "edge_idle_hold");
    frame(1'b0, 0, 0);
    pix(30, 40, 1'b1, 0, 0, "edge_idle_apply");
    pix(29, 40, 1'b0, 0, 0, "edge_idle_left");

    // Strobe on the vblank edge while pending: old pair now, new pair next frame.
    pos(50, 60);
    frame(1'b1, 70, 80);
    pix(50, 60, 1'b1, 0, 0, "edge_pend_old");
    frame(1'b0, 0, 0);
    pix(70, 80, 1'b1, 0, 0, "edge_pend_new");
    pix(50, 60, 1'b0, 0, 0, "edge_pend_gone");

    // Reset while pending discards the pending pair.
    pos(90, 90);
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("midrst_rgb", 32'(rgb_out), 32'h0);
    rst = 1'b0;
    pix(0, 0, 1'b1, 0, 0, "midrst_now");
    frame(1'b0, 0, 0);
    pix(0,  0,  1'b1, 0,  0,  "midrst_next");
    pix(90, 90, 1'b1, 90, 90, "midrst_pend_dropped");

    // Key-coloured ROM texel.
    idle_inputs();
    hcount_in = 11'd64;
    vcount_in = 11'd64;
    hblnk_in  = 1'b0;
    rgb_in    = bg(11'd64, 11'd64);
    step();
    check("key_addr", 32'(rom_address), 32'(KEY_ADDR));
    idle_inputs();
    step();
    step();
`ifdef DRAW_IMAGE_TRANSPARENCY_EN
    check("key_pixel", 32'(rgb_out), 32'h123);
`else
    check("key_pixel", 32'(rgb_out), 32'hF0F);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
